// File: rtl/flush_sequencer.sv
// Flush sequencer: arbitrates BRU/CSRU/LSU redirect requests by ROB age.
// It then walks a Moore FSM through CLEAN, DRAIN and REDIRECT to squash
// and restart the front end.
module flush_sequencer #(
  parameter int PTRW     = 6,
  parameter int ADDRW    = 32,
  parameter int DRAINCYC = 2
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             BruReq,
  input  logic [PTRW-1:0]  BruPtr,
  input  logic [ADDRW-1:0] BruPc,
  input  logic             CsruReq,
  input  logic [PTRW-1:0]  CsruPtr,
  input  logic [ADDRW-1:0] CsruPc,
  input  logic             LsuReq,
  input  logic [PTRW-1:0]  LsuPtr,
  input  logic [ADDRW-1:0] LsuPc,
  input  logic             EuIdle,
  output logic             FlushStop,
  output logic             FlushClean,
  output logic [PTRW-1:0]  CleanPtr,
  output logic             RedirectValid,
  output logic [ADDRW-1:0] RedirectPc,
  output logic             Busy,
  output logic [15:0]      FlushCount
);

  localparam int CNTW = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLEAN    = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [PTRW-1:0]  clean_ptr_q, clean_ptr_d;
  logic [ADDRW-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]      flush_count_q, flush_count_d;

  logic             win_req;
  logic [PTRW-1:0]  win_ptr;
  logic [ADDRW-1:0] win_pc;

  // The MSB is a wrap flag: with equal flags the smaller index is older;
  // with differing flags the larger index is older.
  function automatic logic is_older(input logic [PTRW-1:0] a, input logic [PTRW-1:0] b);
    if (a[PTRW-1] == b[PTRW-1]) begin
      return a[PTRW-2:0] < b[PTRW-2:0];
    end else begin
      return a[PTRW-2:0] > b[PTRW-2:0];
    end
  endfunction

  // Oldest requester wins. Candidates are taken in CSRU, LSU, BRU order and
  // only a strictly older one replaces the current pick. Equal pointers
  // therefore keep the higher-priority unit.
  always_comb begin
    win_req = 1'b0;
    win_ptr = '0;
    win_pc  = '0;
    if (CsruReq) begin
      win_req = 1'b1;
      win_ptr = CsruPtr;
      win_pc  = CsruPc;
    end
    if (LsuReq && (!win_req || is_older(LsuPtr, win_ptr))) begin
      win_req = 1'b1;
      win_ptr = LsuPtr;
      win_pc  = LsuPc;
    end
    if (BruReq && (!win_req || is_older(BruPtr, win_ptr))) begin
      win_req = 1'b1;
      win_ptr = BruPtr;
      win_pc  = BruPc;
    end
  end

  // Next-state, drain counter and latched flush target.
  // Preemption by an older request overrides whatever the state decided.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clean_ptr_d   = clean_ptr_q;
    redirect_pc_d = redirect_pc_q;
    flush_count_d = flush_count_q;

    case (state_q)
      S_IDLE: begin
        if (win_req) begin
          clean_ptr_d   = win_ptr;
          redirect_pc_d = win_pc;
          state_d       = S_CLEAN;
        end
      end
      S_CLEAN: begin
        state_d = S_DRAIN;
        cnt_d   = CNTW'(DRAINCYC - 1);
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (EuIdle) begin
            state_d = S_REDIRECT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REDIRECT: begin
        flush_count_d = flush_count_q + 16'd1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && win_req && is_older(win_ptr, clean_ptr_q)) begin
      clean_ptr_d   = win_ptr;
      redirect_pc_d = win_pc;
      state_d       = S_CLEAN;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      clean_ptr_q   <= '0;
      redirect_pc_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clean_ptr_q   <= clean_ptr_d;
      redirect_pc_q <= redirect_pc_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign FlushStop     = (state_q != S_IDLE);
  assign Busy          = (state_q != S_IDLE);
  assign FlushClean    = (state_q == S_CLEAN);
  assign RedirectValid = (state_q == S_REDIRECT);
  assign CleanPtr      = clean_ptr_q;
  assign RedirectPc    = redirect_pc_q;
  assign FlushCount    = flush_count_q;

endmodule
